mem_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter sharing one memory port between instruction fetch (requester 0) and load/store (requester 1).
- Owns the select line of the shared address/wdata/we muxes.
- Sequences each transfer through a small FSM: grant → wait for memory ack → release.
- Includes a timeout so a dead memory cannot hang the core.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter_chk.sv | 38 +++
 rtl/mux2.sv | 18 +
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
// Contents:
//   arb_state_t      - arbiter FSM state (IDLE / BUSY)
//   req_id_t         - requester id (0 = instruction fetch, 1 = load/store)
//   *_DEFAULT        - default address width, data width and timeout
package mem_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef logic req_id_t;

  localparam int AW_DEFAULT      = 32;
  localparam int DW_DEFAULT      = 32;
  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_port_arbiter_chk.sv
// Protocol checker for mem_port_arbiter; instantiated by the arbiter itself.
// Ports:
//   clk, reset_n           - clock and asynchronous active-low reset
//   state                  - arbiter FSM state
//   sel                    - current grant id
//   mem_valid              - shared-port request strobe
//   req0_done, req1_done   - completion pulses
//   rsp_err                - timeout flag
module mem_port_arbiter_chk
  import mem_arb_pkg::*;
(
  input logic       clk,
  input logic       reset_n,
  input arb_state_t state,
  input req_id_t    sel,
  input logic       mem_valid,
  input logic       req0_done,
  input logic       req1_done,
  input logic       rsp_err
);

  // Only one requester can be completed at a time.
  a_done_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    !(req0_done && req1_done));

  // The port is only driven while a transfer is in flight.
  a_valid_busy: assert property (@(posedge clk) disable iff (!reset_n)
    mem_valid |-> (state == BUSY));

  // The grant must not move underneath an active transfer.
  a_sel_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (mem_valid && $past(mem_valid)) |-> (sel == $past(sel)));

  // A timeout flag is meaningless without a completion.
  a_err_done: assert property (@(posedge clk) disable iff (!reset_n)
    rsp_err |-> (req0_done || req1_done));

endmodule

// File: rtl/mux2.sv
// Generic two-input multiplexer.
// Ports:
//   sel - select (0 picks d0, 1 picks d1)
//   d0  - input 0
//   d1  - input 1
//   y   - selected output
module mux2 #(
  parameter int WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch
// (requester 0) and load/store (requester 1). Each transfer runs
// IDLE -> BUSY -> IDLE; a BUSY period that sees no mem_ack for TIMEOUT
// cycles is aborted with rsp_err so a dead memory cannot hang the core.
// Ports:
//   clk, reset_n                       - clock, async active-low reset
//   reqN_valid/addr/we/wdata (N=0,1)   - requester transfer requests
//   reqN_done                          - one-cycle completion pulse
//   rsp_rdata, rsp_err                 - response data / timeout flag
//   sel                                - registered grant id (0 = req0)
//   mem_valid/addr/we/wdata            - shared memory port request
//   mem_ack, mem_rdata                 - memory completion and read data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = AW_DEFAULT,
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic          req0_we,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic          req1_we,
  input  logic [DW-1:0] req1_wdata,
  output logic          req0_done,
  output logic          req1_done,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          sel,
  output logic          mem_valid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t    state_r, state_next_s;
  req_id_t       sel_r, sel_next_s;
  req_id_t       last_r, last_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s;
  logic          done_s;
  logic          err_s;
  logic          busy_s;
  logic          mux_we_s;

  // FSM state, grant, round-robin history and wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      sel_r   <= 1'b0;
      last_r  <= 1'b1;   // so req0 wins the first tie
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_next_s;
      sel_r   <= sel_next_s;
      last_r  <= last_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Arbitration, transfer sequencing and timeout detection.
  always_comb begin
    state_next_s = state_r;
    sel_next_s   = sel_r;
    last_next_s  = last_r;
    cnt_next_s   = cnt_r;
    done_s       = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        // sel only moves here, so it is frozen for the whole BUSY period.
        if (req0_valid && req1_valid) begin
          sel_next_s = ~last_r;
        end else if (req0_valid) begin
          sel_next_s = 1'b0;
        end else if (req1_valid) begin
          sel_next_s = 1'b1;
        end else begin
          sel_next_s = sel_r;
        end
        if (req0_valid || req1_valid) begin
          state_next_s = BUSY;
          cnt_next_s   = {CW{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        // An ack in the final timeout cycle still counts as a clean completion.
        if (mem_ack) begin
          done_s       = 1'b1;
          last_next_s  = sel_r;
          state_next_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          done_s       = 1'b1;
          err_s        = 1'b1;
          last_next_s  = sel_r;
          state_next_s = IDLE;
        end else begin
          cnt_next_s   = cnt_r + CW'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  assign busy_s    = (state_r == BUSY);
  assign sel       = sel_r;
  assign mem_valid = busy_s;
  assign mem_we    = mux_we_s & busy_s;
  assign req0_done = done_s & ~sel_r;
  assign req1_done = done_s &  sel_r;
  assign rsp_err   = err_s;
  assign rsp_rdata = mem_rdata;

  mux2 #(.WIDTH(AW)) u_mux_addr (
    .sel (sel_r),
    .d0  (req0_addr),
    .d1  (req1_addr),
    .y   (mem_addr)
  );

  mux2 #(.WIDTH(DW)) u_mux_wdata (
    .sel (sel_r),
    .d0  (req0_wdata),
    .d1  (req1_wdata),
    .y   (mem_wdata)
  );

  mux2 #(.WIDTH(1)) u_mux_we (
    .sel (sel_r),
    .d0  (req0_we),
    .d1  (req1_we),
    .y   (mux_we_s)
  );

  mem_port_arbiter_chk u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .state     (state_r),
    .sel       (sel_r),
    .mem_valid (busy_s),
    .req0_done (req0_done),
    .req1_done (req1_done),
    .rsp_err   (err_s)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Stimulus pushes the expected
// completion (requester id, read data, error flag) into a queue; a monitor
// pops and compares on every done pulse. Direct checks cover port muxing,
// grant order, latency and reset behaviour.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic          req0_we = 1'b0, req1_we = 1'b0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic          req0_done, req1_done, rsp_err, sel, mem_valid, mem_we;
  logic [DW-1:0] rsp_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_we    (req0_we),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_we    (req1_we),
    .req1_wdata (req1_wdata),
    .req0_done  (req0_done),
    .req1_done  (req1_done),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .sel        (sel),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.id = id;
    e.rdata = rdata;
    e.err = err;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && (req0_done || req1_done)) begin
      exp_t e;
      chk("done_exclusive", 32'(req0_done & req1_done), 32'd0);
      chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("done_id", 32'(req1_done), 32'(e.id));
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) cyc();
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_done0", 32'(req0_done), 32'd0);
    chk("rst_done1", 32'(req1_done), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    reset_n = 1'b1;
    cyc();

    // 1: single read from req0, ack two cycles after mem_valid
    req0_valid = 1'b1; req0_addr = 32'h100; req0_we = 1'b0;
    push(1'b0, 32'hDEADBEEF, 1'b0);
    cyc(); #1;
    chk("t1_mem_valid", 32'(mem_valid), 32'd1);
    chk("t1_sel", 32'(sel), 32'd0);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_we", 32'(mem_we), 32'd0);
    cyc();
    cyc(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk("t1_done0", 32'(req0_done), 32'd1);
    cyc(); mem_ack = 1'b0; req0_valid = 1'b0; #1;
    chk("t1_idle_valid", 32'(mem_valid), 32'd0);
    chk("t1_done_once", 32'(req0_done), 32'd0);

    // 2: both valid from reset, immediate acks -> 0,1,0,1 with idle gaps
    req0_valid = 1'b1; req0_addr = 32'h1000;
    req1_valid = 1'b1; req1_addr = 32'h2000;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(1'(i % 2), 32'hA000_0000 + 32'(i), 1'b0);
      cyc(); mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i); #1;
      chk("t2_sel", 32'(sel), 32'(i % 2));
      chk("t2_addr", mem_addr, (i % 2 == 0) ? 32'h1000 : 32'h2000);
      cyc(); mem_ack = 1'b0; #1;
      chk("t2_gap", 32'(mem_valid), 32'd0);
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end

    // 3: req1 write, req0 arrives mid-BUSY and is served next
    req1_valid = 1'b1; req1_addr = 32'h200; req1_wdata = 32'h55; req1_we = 1'b1;
    mem_rdata = 32'h0;
    push(1'b1, 32'h0, 1'b0);
    cyc(); #1;
    chk("t3_sel", 32'(sel), 32'd1);
    chk("t3_we", 32'(mem_we), 32'd1);
    chk("t3_addr", mem_addr, 32'h200);
    chk("t3_wdata", mem_wdata, 32'h55);
    req0_valid = 1'b1; req0_addr = 32'h300; req0_we = 1'b0;
    cyc(); #1;
    chk("t3_sel_hold", 32'(sel), 32'd1);
    chk("t3_addr_hold", mem_addr, 32'h200);
    chk("t3_we_hold", 32'(mem_we), 32'd1);
    cyc(); mem_ack = 1'b1; #1;
    chk("t3_done1", 32'(req1_done), 32'd1);
    cyc(); mem_ack = 1'b0; req1_valid = 1'b0; req1_we = 1'b0; #1;
    chk("t3_we_idle", 32'(mem_we), 32'd0);
    push(1'b0, 32'h1234_5678, 1'b0);
    cyc(); #1;
    chk("t3_next_sel", 32'(sel), 32'd0);
    chk("t3_next_addr", mem_addr, 32'h300);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    cyc(); mem_ack = 1'b0; req0_valid = 1'b0;

    // 4: no ack -> abort with rsp_err on the 16th BUSY cycle
    req0_valid = 1'b1; req0_addr = 32'h400; mem_rdata = 32'hCAFE_F00D;
    push(1'b0, 32'hCAFE_F00D, 1'b1);
    for (int k = 1; k <= TIMEOUT; k++) begin
      cyc(); #1;
      if (k == 1) chk("t4_valid", 32'(mem_valid), 32'd1);
      if (k < TIMEOUT) begin
        chk("t4_no_early_done", 32'(req0_done), 32'd0);
      end else begin
        chk("t4_done", 32'(req0_done), 32'd1);
        chk("t4_err", 32'(rsp_err), 32'd1);
      end
    end
    cyc(); req0_valid = 1'b0; #1;
    chk("t4_idle", 32'(mem_valid), 32'd0);

    // 4b: ack in the timeout cycle wins -> clean completion
    req0_valid = 1'b1; mem_rdata = 32'h0BAD_0ACE;
    push(1'b0, 32'h0BAD_0ACE, 1'b0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      cyc();
      if (k == TIMEOUT) mem_ack = 1'b1;
    end
    #1;
    chk("t4b_done", 32'(req0_done), 32'd1);
    chk("t4b_err", 32'(rsp_err), 32'd0);
    cyc(); mem_ack = 1'b0; req0_valid = 1'b0;

    // 5: reset mid-BUSY, then re-arbitration from the reset state
    req0_valid = 1'b1; req0_addr = 32'h500;
    cyc(); #1;
    chk("t5_busy", 32'(mem_valid), 32'd1);
    #2 reset_n = 1'b0; #1;
    chk("t5_async_valid", 32'(mem_valid), 32'd0);
    chk("t5_rst_sel", 32'(sel), 32'd0);
    chk("t5_rst_done", 32'(req0_done), 32'd0);
    req1_valid = 1'b1; req1_addr = 32'h600;
    cyc(); cyc();
    reset_n = 1'b1;
    push(1'b0, 32'h5555_AAAA, 1'b0);
    cyc(); mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA; #1;
    chk("t5_first_sel", 32'(sel), 32'd0);
    cyc(); mem_ack = 1'b0; req0_valid = 1'b0;
    push(1'b1, 32'h6666_BBBB, 1'b0);
    cyc(); #1;
    chk("t5_second_sel", 32'(sel), 32'd1);
    req1_valid = 1'b0;   // requester withdraws while granted
    cyc(); mem_ack = 1'b1; mem_rdata = 32'h6666_BBBB; #1;
    chk("t5_drop_done1", 32'(req1_done), 32'd1);
    cyc(); mem_ack = 1'b0;

    // 6: stray ack while idle is ignored
    cyc(); mem_ack = 1'b1; #1;
    chk("t6_done0", 32'(req0_done), 32'd0);
    chk("t6_done1", 32'(req1_done), 32'd0);
    cyc(); mem_ack = 1'b0; #1;
    chk("t6_idle", 32'(mem_valid), 32'd0);

    repeat (3) cyc();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
